// File: rtl/frame_dispatcher.sv
// Egress frame dispatcher: pops tagged frames from the shared forwarding FIFO and
// replicates each one, in lockstep, into the selected per-destination FIFOs.
module frame_dispatcher #(
    parameter logic [1:0]  Port     = 2'h0,
    parameter logic [1:0]  MaxPort  = 2'h3,
    parameter logic [10:0] MaxFrame = 11'd1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [8:0]  dout,
    input  logic        empty,
    output logic        rd_en,
    output logic [8:0]  port0_din,
    output logic [8:0]  port1_din,
    output logic [8:0]  port2_din,
    output logic [8:0]  port3_din,
    output logic [8:0]  nic_din,
    input  logic        port0_full,
    input  logic        port1_full,
    input  logic        port2_full,
    input  logic        port3_full,
    input  logic        nic_full,
    output logic        port0_wr_en,
    output logic        port1_wr_en,
    output logic        port2_wr_en,
    output logic        port3_wr_en,
    output logic        nic_wr_en,
    output logic [15:0] frames_fwd,
    output logic [15:0] frames_drop
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    // Mask bits that may survive filtering: never our own port (no hairpin), never
    // an unpopulated port, always the nic.
    function automatic logic [4:0] keep_mask();
        logic [4:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (2'(i) != Port) && (2'(i) <= MaxPort);
        end
        m[4] = 1'b1;
        return m;
    endfunction

    localparam logic [4:0] KeepMask = keep_mask();

    state_t      state, state_next;
    logic [4:0]  mask_q, mask_next;
    logic [10:0] cnt_q, cnt_next;
    logic [4:0]  wr_q, wr_next;
    logic [8:0]  din_q, din_next;
    logic [15:0] fwd_q, drop_q;
    logic        fwd_inc, drop_inc, pop;
    logic [4:0]  full_vec;
    logic [4:0]  hdr_mask;
    logic        blocked, at_limit;

    assign full_vec = {nic_full, port3_full, port2_full, port1_full, port0_full};
    assign hdr_mask = dout[4:0] & KeepMask;
    assign blocked  = |(mask_q & full_vec);
    assign at_limit = (cnt_q == MaxFrame);

    // NOTE: every variable driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        mask_next  = mask_q;
        cnt_next   = cnt_q;
        wr_next    = 5'b0;
        din_next   = din_q;
        pop        = 1'b0;
        fwd_inc    = 1'b0;
        drop_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (dout[8]) begin
                        mask_next = hdr_mask;
                        cnt_next  = 11'd0;
                        if (|hdr_mask) begin
                            state_next = FWD;
                            fwd_inc    = 1'b1;
                        end else begin
                            state_next = DROP;
                            drop_inc   = 1'b1;
                        end
                    end
                end
            end

            FWD: begin
                if (!empty && !blocked) begin
                    if (dout[8] && at_limit) begin
                        // Oversize: leave the word in the FIFO, close the frame
                        // downstream with a synthetic end marker.
                        wr_next    = mask_q;
                        din_next   = 9'h000;
                        state_next = DROP;
                    end else begin
                        pop      = 1'b1;
                        wr_next  = mask_q;
                        din_next = dout;
                        if (dout[8]) begin
                            cnt_next = cnt_q + 11'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end

            DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!dout[8]) begin
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

        rd_en = pop && !sys_rst;
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            mask_q <= 5'b0;
            cnt_q  <= 11'd0;
            wr_q   <= 5'b0;
            din_q  <= 9'h000;
            fwd_q  <= 16'd0;
            drop_q <= 16'd0;
        end else begin
            state  <= state_next;
            mask_q <= mask_next;
            cnt_q  <= cnt_next;
            wr_q   <= wr_next;
            din_q  <= din_next;
            if (fwd_inc) begin
                fwd_q <= fwd_q + 16'd1;
            end
            if (drop_inc) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // All destinations share one data register; only the strobes differ.
    assign port0_din   = din_q;
    assign port1_din   = din_q;
    assign port2_din   = din_q;
    assign port3_din   = din_q;
    assign nic_din     = din_q;
    assign port0_wr_en = wr_q[0];
    assign port1_wr_en = wr_q[1];
    assign port2_wr_en = wr_q[2];
    assign port3_wr_en = wr_q[3];
    assign nic_wr_en   = wr_q[4];
    assign frames_fwd  = fwd_q;
    assign frames_drop = drop_q;

endmodule
